fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage for the RV32I core, directly upstream of instruct_mem.
//  - Owns the PC register and drives Program_Count into instruct_mem; instruct_mem reads asynchronously.
//  - Captures the returned Instruction with its PC into a small FIFO.
//  - Presents FIFO entries to decode over a valid/ready handshake.
//  - Redirects (branch/jump from execute) flush the FIFO and reload the PC.
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  PC value loaded on reset
//  FIFO_DEPTH    2              fetch FIFO entries; power of 2, >= 2
// PORTS
//  Clk_Core         in   1   core clock, all state on rising edge
//  Rst_Core         in   1   reset: synchronous, active-high
//  Program_Count    out  32  fetch address to instruct_mem (registered PC)
//  Instruction      in   32  instruct_mem read data for Program_Count, same cycle
//  Redirect_Valid   in   1   taken branch/jump this cycle
//  Redirect_Target  in   32  new fetch address, qualified by Redirect_Valid
//  Fetch_Valid      out  1   FIFO head valid to decode
//  Fetch_Ready      in   1   decode accepts head this cycle
//  Fetch_Instr      out  32  head instruction
//  Fetch_PC         out  32  head PC
//  Fetch_Misalign   out  1   head carries misaligned-target trap (0 unless macro set)
// BEHAVIOUR
//  - Reset values: Program_Count=RESET_VECTOR; FIFO empty; Fetch_Valid=0; Fetch_Instr=0;
//    Fetch_PC=0; Fetch_Misalign=0; state=RUN.
//  - Reset dominates Redirect_Valid and all other events.
//  - Handshake:
//    - pop = Fetch_Valid & Fetch_Ready.
//    - Fetch_Valid = !empty & !Redirect_Valid (combinational kill on redirect).
//    - Head outputs hold stable while Fetch_Valid=1 and Fetch_Ready=0.
//  - Push:
//    - In RUN, with no redirect, push {Program_Count, Instruction, 0} when count<FIFO_DEPTH,
//      or when count==FIFO_DEPTH and pop is asserted (simultaneous push/pop on full is allowed).
//    - On a push, PC <= PC+4, modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
//    - No push -> PC holds.
//  - Redirect (priority over push/pop):
//    - At the edge: FIFO flushed (count=0, pointers=0) and PC <= target; no push that cycle.
//    - Target entry is pushed at the next edge and is Fetch_Valid one cycle later.
//      Redirect-to-valid latency is 2 edges.
//    - Back-to-back redirects: the last one wins.
//  - Occupancy:
//    - count in 0..FIFO_DEPTH; rd/wr pointers wrap modulo FIFO_DEPTH.
//    - Pop on empty is impossible; Fetch_Valid gates it.
//    - Simultaneous push+pop leaves count unchanged.
//  - State machine (macro only): RUN -> TRAP -> HALT -> RUN.
//    - RUN: normal fetch.
//    - TRAP: one cycle; push {target, NOP_INSTR, 1} regardless of Instruction; go to HALT.
//      If the FIFO is full, TRAP waits for a free slot.
//    - HALT: no pushes; PC holds.
//    - Any aligned redirect -> RUN. A misaligned redirect in any state -> TRAP.
// CONFIGURATION
//  FETCH_MISALIGN_TRAP_EN
//  - Defined:
//    - Redirect_Target[1:0]!=0 enters TRAP with PC <= target unmodified.
//    - Decode sees exactly one entry with Fetch_Misalign=1, Fetch_Instr=NOP_INSTR, Fetch_PC=target.
//    - Fetch then halts until the next redirect.
//  - Undefined:
//    - Target low bits are forced to 2'b00; state stays RUN.
//    - Fetch_Misalign is tied to 0; the TRAP/HALT logic is absent.
// STRUCTURE
//  - fetch_pkg:
//    - NOP_INSTR = 32'h0000_0013.
//    - fetch_state_t {RUN, TRAP, HALT}.
//    - fetch_entry_t {pc[31:0], instr[31:0], misalign}.
//    - Default RESET_VECTOR.
//  - Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with flush input.
//    - Ports: push, pop, flush, full, empty, head.
//    - Flush has priority over push/pop.
//  - fetch_unit top: PC register, next-PC mux, push control, optional state machine.
// TESTING
//  1. Assert Rst_Core 2 cycles, then release, mem[0]=0x00500093
//     -> Program_Count=0 during reset, Fetch_Valid=0; one edge after release
//        Fetch_Valid=1, Fetch_PC=0, Fetch_Instr=0x00500093.
//  2. Fetch_Ready=0 from reset
//     -> two pushes, Program_Count stops at 0x8; head holds PC 0x0 until Ready=1;
//        the first pop allows a push of PC 0x8 on the same edge.
//  3. Fetch_Ready=1 continuously
//     -> one accepted entry per cycle, Fetch_PC 0x0,0x4,0x8,... with matching mem words, no gaps.
//  4. FIFO full (PCs 0x10,0x14), Redirect_Valid=1, target 0x100
//     -> Fetch_Valid=0 that cycle; PC=0x100 next cycle; entry PC 0x100 is Fetch_Valid
//        2 edges after the redirect; PCs 0x10/0x14 never accepted.
//  5. RESET_VECTOR=32'hFFFF_FFFC, Ready=1 -> Fetch_PC 0xFFFF_FFFC then 0x0000_0000.
//  6. Macro defined, redirect target 0x102
//     -> one entry {0x102, 0x00000013, Misalign=1}, then Fetch_Valid=0 through HALT;
//        redirect to 0x200 resumes with Fetch_PC=0x200.
//        Macro undefined, same stimulus -> Fetch_PC=0x100, Misalign=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and types for the RV32I instruction fetch stage.
// The FETCH_MISALIGN_TRAP_EN build uses fetch_state_t and NOP_INSTR.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] ALIGN_MASK           = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    TRAP = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        misalign;
  } fetch_entry_t;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: instruct_mem address/data, execute redirect, and decode handshake.
interface fetch_if;

  logic [31:0] Program_Count;
  logic [31:0] Instruction;
  logic        Redirect_Valid;
  logic [31:0] Redirect_Target;
  logic        Fetch_Valid;
  logic        Fetch_Ready;
  logic [31:0] Fetch_Instr;
  logic [31:0] Fetch_PC;
  logic        Fetch_Misalign;

  modport master (
    output Program_Count,
    input  Instruction,
    input  Redirect_Valid,
    input  Redirect_Target,
    output Fetch_Valid,
    input  Fetch_Ready,
    output Fetch_Instr,
    output Fetch_PC,
    output Fetch_Misalign
  );

  modport slave (
    input  Program_Count,
    output Instruction,
    output Redirect_Valid,
    output Redirect_Target,
    input  Fetch_Valid,
    output Fetch_Ready,
    input  Fetch_Instr,
    input  Fetch_PC,
    input  Fetch_Misalign
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with a flush that overrides push and pop.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t entry,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == '0);
  // Empty head reads as zero so decode never sees uninitialised storage.
  assign head  = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every signal gets its default first so no path leaves it unassigned (no latch).
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = entry;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: the entry storage is deliberately not reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so all flops sample together.
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: PC register, next-PC mux, push control into fetch_fifo.
// Optional misaligned-redirect trap (RUN/TRAP/HALT) enabled by FETCH_MISALIGN_TRAP_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int          FIFO_DEPTH   = 2
) (
  input logic     Clk_Core,
  input logic     Rst_Core,
  fetch_if.master bus
);

  logic [31:0]  pc_q, pc_d;
  logic         push, pop, flush, slot_free;
  logic         fifo_full, fifo_empty, fetch_valid;
  fetch_entry_t push_entry, head;

`ifdef FETCH_MISALIGN_TRAP_EN
  fetch_state_t state_q, state_d;
`endif

  // A redirect kills the head combinationally so decode never consumes a wrong-path entry.
  assign fetch_valid = !fifo_empty && !bus.Redirect_Valid;
  assign pop         = fetch_valid && bus.Fetch_Ready;
  assign flush       = bus.Redirect_Valid;
  assign slot_free   = !fifo_full || pop;

  assign bus.Program_Count  = pc_q;
  assign bus.Fetch_Valid    = fetch_valid;
  assign bus.Fetch_Instr    = head.instr;
  assign bus.Fetch_PC       = head.pc;
  // Without the trap build no entry is ever pushed with misalign set.
  assign bus.Fetch_Misalign = head.misalign;

  always_comb begin
    pc_d       = pc_q;
    push       = 1'b0;
    push_entry = '{pc: pc_q, instr: bus.Instruction, misalign: 1'b0};
`ifdef FETCH_MISALIGN_TRAP_EN
    state_d    = state_q;
    if (bus.Redirect_Valid) begin
      pc_d    = bus.Redirect_Target;
      state_d = is_misaligned(bus.Redirect_Target) ? TRAP : RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (slot_free) begin
            push = 1'b1;
            pc_d = pc_q + 32'd4;
          end
        end
        TRAP: begin
          // PC already holds the faulting target; emit the marker entry once.
          if (slot_free) begin
            push       = 1'b1;
            push_entry = '{pc: pc_q, instr: NOP_INSTR, misalign: 1'b1};
            state_d    = HALT;
          end
        end
        HALT:    state_d = HALT;
        default: state_d = RUN;
      endcase
    end
`else
    if (bus.Redirect_Valid) begin
      pc_d = bus.Redirect_Target & ALIGN_MASK;
    end else if (slot_free) begin
      push = 1'b1;
      pc_d = pc_q + 32'd4;
    end
`endif
  end

  always_ff @(posedge Clk_Core) begin
    if (Rst_Core) begin
      pc_q    <= RESET_VECTOR;
`ifdef FETCH_MISALIGN_TRAP_EN
      state_q <= RUN;
`endif
    end else begin
      pc_q    <= pc_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      state_q <= state_d;
`endif
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (Clk_Core),
    .rst   (Rst_Core),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .entry (push_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand sequences,
// and randomized traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int DEPTH = 2;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rst2 = 1'b1;
  always #5 clk = ~clk;

  fetch_if bus_if ();
  fetch_if bus2_if ();

  fetch_unit #(.RESET_VECTOR(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
    .Clk_Core (clk),
    .Rst_Core (rst),
    .bus      (bus_if)
  );

  fetch_unit #(.RESET_VECTOR(32'hFFFF_FFFC), .FIFO_DEPTH(DEPTH)) dut_wrap (
    .Clk_Core (clk),
    .Rst_Core (rst2),
    .bus      (bus2_if)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  assign bus_if.Instruction  = mem_word(bus_if.Program_Count);
  assign bus2_if.Instruction = mem_word(bus2_if.Program_Count);

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rv, input logic [31:0] tgt, input logic rdy);
    bus_if.Redirect_Valid  = rv;
    bus_if.Redirect_Target = tgt;
    bus_if.Fetch_Ready     = rdy;
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc,
                            input logic [31:0] instr, input logic mis);
    check({tag, "_valid"}, 32'(bus_if.Fetch_Valid), 32'd1);
    check({tag, "_pc"},    bus_if.Fetch_PC, pc);
    check({tag, "_instr"}, bus_if.Fetch_Instr, instr);
    check({tag, "_mis"},   32'(bus_if.Fetch_Misalign), {31'd0, mis});
  endtask

  typedef struct packed {
    logic        rv;
    logic [31:0] tgt;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] ecnt;
  } vec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
  } m_ent_t;

  vec_t   vec [16];
  m_ent_t m_q [$];
  logic [31:0] m_pc;
  int          m_mode;  // 0 fetching, 1 trap pending, 2 halted

  initial begin
    // Directed stimulus: stall from reset, stream, redirect on full, back-to-back redirects.
    vec[0]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0};
    vec[1]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h0,   32'h4};
    vec[2]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h0,   32'h8};
    vec[3]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h0,   32'h8};
    vec[4]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   32'h8};
    vec[5]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h4,   32'hC};
    vec[6]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h8,   32'h10};
    vec[7]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'hC,   32'h14};
    vec[8]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h10,  32'h18};
    vec[9]  = '{1'b1, 32'h100, 1'b1, 1'b0, 32'h0,   32'h18};
    vec[10] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   32'h100};
    vec[11] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 32'h104};
    vec[12] = '{1'b1, 32'h200, 1'b1, 1'b0, 32'h0,   32'h108};
    vec[13] = '{1'b1, 32'h300, 1'b1, 1'b0, 32'h0,   32'h200};
    vec[14] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   32'h300};
    vec[15] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h300, 32'h304};

    drive(1'b0, 32'h0, 1'b0);
    bus2_if.Redirect_Valid  = 1'b0;
    bus2_if.Redirect_Target = 32'h0;
    bus2_if.Fetch_Ready     = 1'b1;

    // Reset held for two edges.
    @(negedge clk);
    check("rst_pcnt",  bus_if.Program_Count, 32'h0);
    check("rst_valid", 32'(bus_if.Fetch_Valid), 32'd0);
    check("rst_fpc",   bus_if.Fetch_PC, 32'h0);
    check("rst_instr", bus_if.Fetch_Instr, 32'h0);
    check("rst_mis",   32'(bus_if.Fetch_Misalign), 32'd0);
    @(negedge clk);
    check("rst2_pcnt",  bus_if.Program_Count, 32'h0);
    check("rst2_valid", 32'(bus_if.Fetch_Valid), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      drive(vec[i].rv, vec[i].tgt, vec[i].rdy);
      #1;
      check($sformatf("vec%0d_pcnt", i), bus_if.Program_Count, vec[i].ecnt);
      if (vec[i].ev) check_head($sformatf("vec%0d", i), vec[i].epc, mem_word(vec[i].epc), 1'b0);
      else check($sformatf("vec%0d_valid", i), 32'(bus_if.Fetch_Valid), 32'd0);
      @(negedge clk);
    end

    // PC wrap from 0xFFFF_FFFC to 0.
    rst2 = 1'b0;
    #1;
    check("wrap0_pcnt",  bus2_if.Program_Count, 32'hFFFF_FFFC);
    check("wrap0_valid", 32'(bus2_if.Fetch_Valid), 32'd0);
    @(negedge clk);
    #1;
    check("wrap1_valid", 32'(bus2_if.Fetch_Valid), 32'd1);
    check("wrap1_fpc",   bus2_if.Fetch_PC, 32'hFFFF_FFFC);
    check("wrap1_pcnt",  bus2_if.Program_Count, 32'h0);
    @(negedge clk);
    #1;
    check("wrap2_fpc",   bus2_if.Fetch_PC, 32'h0);
    check("wrap2_instr", bus2_if.Fetch_Instr, 32'h0050_0093);
    @(negedge clk);

    // Misaligned redirect to 0x102.
    drive(1'b1, 32'h102, 1'b1);
    #1;
    check("mis_kill", 32'(bus_if.Fetch_Valid), 32'd0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1);
    #1;
    check("mis_wait", 32'(bus_if.Fetch_Valid), 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("mis_pcnt", bus_if.Program_Count, 32'h102);
    @(negedge clk);
    #1;
    check_head("mis_head", 32'h102, NOP_INSTR, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("halt%0d_valid", k), 32'(bus_if.Fetch_Valid), 32'd0);
    end
`else
    check("mis_pcnt", bus_if.Program_Count, 32'h100);
    @(negedge clk);
    #1;
    check_head("mis_head", 32'h100, mem_word(32'h100), 1'b0);
    @(negedge clk);
    #1;
    check_head("mis_next", 32'h104, mem_word(32'h104), 1'b0);
`endif
    @(negedge clk);
    drive(1'b1, 32'h200, 1'b1);
    #1;
    check("resume_kill", 32'(bus_if.Fetch_Valid), 32'd0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1);
    #1;
    check("resume_wait", 32'(bus_if.Fetch_Valid), 32'd0);
    @(negedge clk);
    #1;
    check_head("resume", 32'h200, mem_word(32'h200), 1'b0);
    @(negedge clk);

    // Randomized traffic against the queue model.
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    m_q.delete();
    m_pc   = 32'h0;
    m_mode = 0;
    for (int n = 0; n < 3000; n++) begin
      logic        r_rst, rv, rdy, ev;
      logic [31:0] tgt, rnd;
      r_rst = ($urandom_range(0, 99) == 0);
      rv    = ($urandom_range(0, 7) == 0);
      rdy   = ($urandom_range(0, 3) != 0);
      rnd   = $urandom;
      if ($urandom_range(0, 3) == 0) rnd = rnd | 32'hFFFF_FF00;
      tgt   = ($urandom_range(0, 3) == 0) ? rnd : (rnd & 32'hFFFF_FFFC);
      rst   = r_rst;
      drive(rv, tgt, rdy);
      #1;
      ev = (m_q.size() != 0) && !rv;
      check("rnd_valid", 32'(bus_if.Fetch_Valid), {31'd0, ev});
      check("rnd_pcnt",  bus_if.Program_Count, m_pc);
      if (ev) begin
        check("rnd_fpc",   bus_if.Fetch_PC, m_q[0].pc);
        check("rnd_instr", bus_if.Fetch_Instr, m_q[0].instr);
        check("rnd_mis",   32'(bus_if.Fetch_Misalign), {31'd0, m_q[0].mis});
      end
      if (r_rst) begin
        m_q.delete();
        m_pc   = 32'h0;
        m_mode = 0;
      end else if (rv) begin
        m_q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
        m_pc   = tgt;
        m_mode = (tgt % 4 != 0) ? 1 : 0;
`else
        m_pc   = tgt - (tgt % 4);
`endif
      end else begin
        if (ev && rdy) void'(m_q.pop_front());
        if (m_q.size() < DEPTH) begin
          if (m_mode == 0) begin
            m_q.push_back('{m_pc, mem_word(m_pc), 1'b0});
            m_pc = m_pc + 32'd4;
          end else if (m_mode == 1) begin
            m_q.push_back('{m_pc, NOP_INSTR, 1'b1});
            m_mode = 2;
          end
        end
      end
      @(negedge clk);
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
